// File: rtl/disp_share_arbiter.sv
// disp_share_arbiter: round-robin time-slicing owner of the 8-digit seven-segment display.
// Ports: clk, rst (sync, active-high), req/data_in per source -> grant, owner, owner_valid, digits_out, switch_pulse.
module disp_share_arbiter #(
    parameter int          N_REQ        = 4,
    parameter int          DWELL_CYCLES = 100_000_000,
    parameter int          GAP_CYCLES   = 2,
    parameter logic [3:0]  BLANK_NIBBLE = 4'hF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [32*N_REQ-1:0]        data_in,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       owner_valid,
    output logic [31:0]                digits_out,
    output logic                       switch_pulse
);

    localparam int OW = $clog2(N_REQ);
    localparam int DW = $clog2(DWELL_CYCLES);
    // A zero-cycle gap still needs a 1-bit counter to keep widths legal.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [31:0]   BLANK_WORD = {8{BLANK_NIBBLE}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [OW-1:0]   ptr, ptr_n;
    logic [OW-1:0]   owner_n;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic [GW-1:0]   gcnt, gcnt_n;
    logic            pulse_n;

    logic [OW-1:0]   win;
    logic [OW-1:0]   cand;
    logic            any_req;
    logic            others;
    logic            leave;
    logic            arb;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        win     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OW'((int'(ptr) + k) % N_REQ);
            if (!any_req && req[cand]) begin
                win     = cand;
                any_req = 1'b1;
            end
        end
    end

    assign others = |(req & ~(N_REQ'(1) << owner));

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        dcnt_n  = dcnt;
        gcnt_n  = gcnt;
        pulse_n = 1'b0;
        leave   = 1'b0;
        arb     = 1'b0;

        unique case (state)
            IDLE: arb = 1'b1;
            HOLD: begin
                if (!req[owner]) begin
                    dcnt_n = '0;
                    leave  = 1'b1;
                end else if (dcnt == DWELL_LAST) begin
                    // Uncontended owner simply starts a fresh slice.
                    dcnt_n = '0;
                    leave  = others;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    gcnt_n = '0;
                    arb    = 1'b1;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (leave) begin
            if (GAP_CYCLES > 0) begin
                state_n = GAP;
                gcnt_n  = '0;
            end else begin
                arb = 1'b1;
            end
        end

        if (arb) begin
            if (any_req) begin
                state_n = HOLD;
                owner_n = win;
                ptr_n   = win;
                dcnt_n  = '0;
                pulse_n = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end
    end

    // Outputs use the next-state owner so data lands on the same edge as grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= OW'(N_REQ - 1);
            owner        <= '0;
            dcnt         <= '0;
            gcnt         <= '0;
            grant        <= '0;
            owner_valid  <= 1'b0;
            switch_pulse <= 1'b0;
            digits_out   <= BLANK_WORD;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            owner        <= owner_n;
            dcnt         <= dcnt_n;
            gcnt         <= gcnt_n;
            switch_pulse <= pulse_n;
            owner_valid  <= (state_n == HOLD);
            if (state_n == HOLD) begin
                grant      <= N_REQ'(1) << owner_n;
                digits_out <= data_in[32*owner_n +: 32];
            end else begin
                grant      <= '0;
                digits_out <= BLANK_WORD;
            end
        end
    end

endmodule
